// File: rtl/rv32i_types.sv
// Types shared across the RV32 datapath blocks.
package rv32i_types;

    // M-extension operation select, in funct3 order.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one radix-2 step per cycle on magnitudes,
// sign fixed up on the way into DONE. Divide-by-zero and signed overflow
// bypass the iteration entirely.
module muldiv_iter
    import rv32i_types::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  muldiv_op_t       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_f,
    output logic [TAG_W-1:0] resp_tag,
    input  logic             flush
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    muldiv_op_t        op_q;
    logic [WIDTH-1:0]  b_mag;
    logic              a_neg;
    logic              b_neg;
    logic [2*WIDTH-1:0] acc;

    // Two's-complement negation helpers for single and double width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    // Magnitude of an operand; unsigned operands pass through untouched.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    logic                     a_sgn;
    logic                     b_sgn;
    logic                     div_zero;
    logic                     div_ovf;
    logic                     accept;
    logic [WIDTH:0]           mul_sum;
    logic [2*WIDTH-1:0]       mul_next;
    logic [WIDTH:0]           rem_sh;
    logic                     div_ge;
    logic [WIDTH-1:0]         div_diff;
    logic [2*WIDTH-1:0]       div_next;
    logic [2*WIDTH-1:0]       step_next;
    logic [2*WIDTH-1:0]       prod;
    logic [WIDTH-1:0]         quo;
    logic [WIDTH-1:0]         rmd;
    logic [WIDTH-1:0]         result;

    // Request decode: which operands are signed, and the two bypass cases.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (req_op)
            MD_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; end
            MD_MULHSU: begin a_sgn = 1'b1; b_sgn = 1'b0; end
            MD_DIV:    begin a_sgn = 1'b1; b_sgn = 1'b1; end
            MD_REM:    begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default:   begin a_sgn = 1'b0; b_sgn = 1'b0; end
        endcase
        div_zero = req_op[2] && (req_b == '0);
        div_ovf  = ((req_op == MD_DIV) || (req_op == MD_REM)) &&
                   ($signed(req_a) == MOST_NEG) && ($signed(req_b) == MINUS_ONE);
        accept   = (state == IDLE) && req_valid && req_ready && !flush;
    end

    // One iteration step plus sign-corrected result of that step.
    always_comb begin
        // shift-add: acc = {partial high, remaining multiplier bits}
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        // restoring divide: acc = {partial remainder, dividend/quotient bits}
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (rem_sh >= {1'b0, b_mag});
        div_diff = rem_sh[WIDTH-1:0] - b_mag;
        div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        step_next = op_q[2] ? div_next : mul_next;

        prod = (a_neg ^ b_neg) ? neg_d(step_next) : step_next;
        quo  = (a_neg ^ b_neg) ? neg_w(step_next[WIDTH-1:0]) : step_next[WIDTH-1:0];
        rmd  = a_neg ? neg_w(step_next[2*WIDTH-1:WIDTH]) : step_next[2*WIDTH-1:WIDTH];

        case (op_q)
            MD_MUL:                      result = prod[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:             result = quo;
            default:                     result = rmd;
        endcase
    end

    // Datapath registers: operands captured on accept, accumulator stepped in CALC.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= req_op;
            a_neg <= a_sgn & req_a[WIDTH-1];
            b_neg <= b_sgn & req_b[WIDTH-1];
            b_mag <= mag_w(req_b, b_sgn);
            acc   <= {{WIDTH{1'b0}}, mag_w(req_a, a_sgn)};
        end else if (state == CALC) begin
            acc <= step_next;
        end
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_f     <= '0;
            resp_tag   <= '0;
        end else if (flush) begin
            state      <= IDLE;
            count      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        resp_tag  <= req_tag;
                        req_ready <= 1'b0;
                        count     <= '0;
                        if (div_zero) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_f     <= ((req_op == MD_DIV) || (req_op == MD_DIVU)) ? '1 : req_a;
                        end else if (div_ovf) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_f     <= (req_op == MD_DIV) ? req_a : '0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // last step and sign fix-up land on the same edge
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_f     <= result;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
